width_8to16_arb: RTL and testbench
==================================

# width_8to16_arb

Multi-channel front end for the 8-to-16 width converter. N_CH independent byte streams compete for one shared packer. A round-robin arbiter grants one channel per 16-bit word and holds that grant until both bytes of the pair arrive, so bytes from different channels are never interleaved. A timeout releases a channel that stalls mid-pair. The packed word leaves with a single-cycle valid pulse and a channel tag.

## Interface

Parameters:
- N_CH, 4, number of byte-stream requesters (2..8)
- CH_W, $clog2(N_CH), width of channel tag
- TIMEOUT, 15, idle cycles allowed while a grant is held before abandoning the pair (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset; all state clears immediately on assertion
- req_valid  in  N_CH  per-channel byte valid
- req_data  in  N_CH*8  per-channel byte; channel i occupies bits [8i+7:8i]
- req_ready  out  N_CH  per-channel accept, combinational from state and grant
- valid_out  out  1  one-cycle pulse, data_out/ch_out valid
- data_out  out  16  packed word {first byte, second byte}
- ch_out  out  CH_W  channel that produced data_out
- err_timeout  out  1  one-cycle pulse when a held grant is abandoned
- err_ch  out  CH_W  channel that timed out

## Operation

- FSM states:
  - ARB:
    - req_ready all 0.
    - If any req_valid: grant = first set bit searching from ptr upward with wrap; go to BYTE0.
    - Otherwise stay in ARB.
  - BYTE0:
    - req_ready[grant]=1; all others 0.
    - On req_valid[grant]: latch the byte into hi_reg, clear the idle counter, go to BYTE1.
  - BYTE1:
    - req_ready[grant]=1.
    - On req_valid[grant]: register data_out={hi_reg, byte}, ch_out=grant, pulse valid_out; set ptr=grant+1 (mod N_CH); go to ARB.
- Idle counter:
  - Counts cycles in BYTE0 or BYTE1 with req_valid[grant]=0.
  - When it reaches TIMEOUT: pulse err_timeout, set err_ch=grant, discard hi_reg contents, set ptr=grant+1, go to ARB. The counter clears.
  - No byte is accepted in the timeout cycle; req_ready[grant]=0 when the counter equals TIMEOUT.
- Channels without a grant see req_ready=0 and must hold their data; they are never dropped.
- No downstream backpressure. valid_out is a pulse, and data_out/ch_out hold their last value between pulses.
- Reset values:
  - state=ARB, ptr=0, grant=0, hi_reg=0, counter=0
  - valid_out=0, data_out=0, ch_out=0, err_timeout=0, err_ch=0
- A reset mid-pair discards the partial byte; there is no output after reset.

## Timing

- Grant decision takes 1 cycle in ARB and is registered.
- Bytes are accepted at earliest one cycle apart.
- Minimum 3 cycles per word: ARB → BYTE0 → BYTE1.
- valid_out is asserted the cycle after the second-byte handshake (req_valid & req_ready sampled at a rising edge).
- Back-to-back words from the same channel are only possible when no other channel is requesting; otherwise round-robin rotates.
- A timeout fires exactly TIMEOUT consecutive stalled cycles after the last accepted byte or grant entry.
  - A stall that ends at count TIMEOUT-1 does not time out.
- Simultaneous events:
  - A request arriving on a non-granted channel during BYTE0/BYTE1 has no effect until the next ARB.
  - req_valid dropping in ARB after the grant decision does not cancel the grant; the counter handles it.

## Structure

- Shared package width_pkg:
  - BYTE_W=8, WORD_W=16
  - state enum {ARB, BYTE0, BYTE1}
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr. Outputs: grant index and any flag.
  - Reusable by other arbiters in the codebase.
- The top holds the FSM, hi_reg, idle counter, and output registers.

## Test plan

- Reset: hold rst_n=0 with random req_valid → all outputs 0, req_ready=0. Release → ARB, with the first grant going to the lowest requesting index ≥0.
- Single channel: ch1 sends 0xA5 then 0x3C → valid_out 1 cycle later with data_out=0xA53C, ch_out=1; 3-cycle word rate when streaming.
- Contention: ch0 and ch2 continuously valid with bytes 0x11,0x22 / 0x33,0x44 → outputs alternate 0x1122 (ch0), 0x3344 (ch2), with no interleaving of bytes.
- Timeout: ch3 sends 0x55 then deasserts for TIMEOUT=15 cycles → err_timeout pulse with err_ch=3, no valid_out. The next grant goes to ch0 if it is requesting. A 14-cycle stall followed by 0x66 → data_out=0x5566.
- Wrap: ptr=3 with N_CH=4 and requests on ch0 and ch3 → ch3 is granted first, then ch0.
- Async reset while in BYTE1 with hi_reg=0x77 → outputs clear immediately, and the partial pair never appears on data_out.

Source files
------------

// File: rtl/width_pkg.sv
// -----------------------------------------------------------------------------
// width_pkg
// Shared widths and FSM state encoding for the 8-to-16 width converter
// front end and related blocks.
// -----------------------------------------------------------------------------
package width_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2
    } state_e;

endpackage : width_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first set bit of req_i,
// searching upward from ptr_i and wrapping past N-1 back to 0.
//
// Ports:
//   req_i    in   N   request vector
//   ptr_i    in   W   index with highest priority this cycle
//   grant_o  out  W   selected index (0 when nothing is requesting)
//   any_o    out  1   at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);

    logic [W-1:0] idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/width_8to16_arb.sv
// -----------------------------------------------------------------------------
// width_8to16_arb
// Round-robin front end that lets N_CH byte streams share one 8-to-16 packer.
// A channel keeps its grant until both bytes of a pair are accepted, so bytes
// from different channels never interleave. A stalled pair is abandoned after
// TIMEOUT idle cycles.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        async active-low reset
//   req_valid    in   N_CH     per-channel byte valid
//   req_data     in   N_CH*8   per-channel byte, channel i at [8i+7:8i]
//   req_ready    out  N_CH     per-channel accept (combinational)
//   valid_out    out  1        one-cycle pulse, data_out/ch_out valid
//   data_out     out  16       {first byte, second byte}
//   ch_out       out  CH_W     channel that produced data_out
//   err_timeout  out  1        one-cycle pulse when a grant is abandoned
//   err_ch       out  CH_W     channel that timed out
//
// state | meaning
// ARB   | pick next channel round-robin from ptr, no byte accepted
// BYTE0 | grant held, waiting for first (high) byte
// BYTE1 | grant held, waiting for second (low) byte
// -----------------------------------------------------------------------------
module width_8to16_arb
    import width_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = $clog2(N_CH),
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        req_valid,
    input  logic [N_CH*BYTE_W-1:0] req_data,
    output logic [N_CH-1:0]        req_ready,
    output logic                   valid_out,
    output logic [WORD_W-1:0]      data_out,
    output logic [CH_W-1:0]        ch_out,
    output logic                   err_timeout,
    output logic [CH_W-1:0]        err_ch
);

    localparam logic [7:0] IDLE_LD = 8'(TIMEOUT);

    state_e              state_q,  state_d;
    logic [CH_W-1:0]     ptr_q,    ptr_d;
    logic [CH_W-1:0]     grant_q,  grant_d;
    logic [BYTE_W-1:0]   hi_q,     hi_d;
    logic [7:0]          idle_q,   idle_d;
    logic                valid_q,  valid_d;
    logic [WORD_W-1:0]   data_q,   data_d;
    logic [CH_W-1:0]     ch_q,     ch_d;
    logic                err_q,    err_d;
    logic [CH_W-1:0]     err_ch_q, err_ch_d;

    logic [BYTE_W-1:0]   ch_byte [N_CH];
    logic [BYTE_W-1:0]   gnt_byte;
    logic                gnt_valid;
    logic [CH_W-1:0]     pick_grant;
    logic                pick_any;
    logic [CH_W-1:0]     ptr_next;
    logic                timed_out;
    logic [N_CH-1:0]     ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign ch_byte[i] = req_data[BYTE_W*i +: BYTE_W];
    end

    assign gnt_byte  = ch_byte[grant_q];
    assign gnt_valid = req_valid[grant_q];

    rr_pick #(
        .N (N_CH),
        .W (CH_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    assign ptr_next = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;

    // Idle timer is a down-counter loaded on grant entry and on every accepted
    // byte; reaching zero while a grant is held means TIMEOUT stalled cycles.
    assign timed_out = (state_q != ARB) && (idle_q == '0);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        hi_d     = hi_q;
        idle_d   = idle_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        ch_d     = ch_q;
        err_d    = 1'b0;
        err_ch_d = err_ch_q;
        ready    = '0;

        unique case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    idle_d  = IDLE_LD;
                    state_d = BYTE0;
                end
            end
            BYTE0, BYTE1: begin
                if (timed_out) begin
                    err_d    = 1'b1;
                    err_ch_d = grant_q;
                    hi_d     = '0;
                    idle_d   = '0;
                    ptr_d    = ptr_next;
                    state_d  = ARB;
                end else begin
                    ready[grant_q] = 1'b1;
                    if (gnt_valid) begin
                        idle_d = IDLE_LD;
                        if (state_q == BYTE0) begin
                            hi_d    = gnt_byte;
                            state_d = BYTE1;
                        end else begin
                            data_d  = {hi_q, gnt_byte};
                            ch_d    = grant_q;
                            valid_d = 1'b1;
                            idle_d  = '0;
                            ptr_d   = ptr_next;
                            state_d = ARB;
                        end
                    end else begin
                        idle_d = idle_q - 8'd1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            grant_q  <= '0;
            hi_q     <= '0;
            idle_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ch_q     <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            hi_q     <= hi_d;
            idle_q   <= idle_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
        end
    end

    assign req_ready   = ready;
    assign valid_out   = valid_q;
    assign data_out    = data_q;
    assign ch_out      = ch_q;
    assign err_timeout = err_q;
    assign err_ch      = err_ch_q;

endmodule : width_8to16_arb

// File: tb/tb_width_8to16_arb.sv
// -----------------------------------------------------------------------------
// tb_width_8to16_arb
// Scoreboard bench for width_8to16_arb with N_CH=4, TIMEOUT=15. Each channel
// has a byte feed queue (with an optional pre-byte gap); expected words and
// timeout events are queued when stimulus is scheduled and checked as the
// DUT produces them.
// -----------------------------------------------------------------------------
module tb_width_8to16_arb;

    localparam int NC = 4;
    localparam int TO = 15;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        valid_out;
    logic [15:0] data_out;
    logic [1:0]  ch_out;
    logic        err_timeout;
    logic [1:0]  err_ch;

    width_8to16_arb #(
        .N_CH    (NC),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ch_out      (ch_out),
        .err_timeout (err_timeout),
        .err_ch      (err_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          cyc;
    logic [7:0]  fb [NC][$];
    int          fg [NC][$];
    int          gap_cnt [NC];
    int          hs_cyc [NC];
    exp_t        sb_w [$];
    int          sb_e [$];
    int          vq [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [3:0]  v;
        logic [31:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NC; i++) begin
            if (gap_cnt[i] == 0 && fb[i].size() != 0) begin
                v[i] = 1'b1;
                d[8*i +: 8] = fb[i][0];
            end
        end
        req_valid = v;
        req_data  = d;
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b, input int g);
        if (fb[ch].size() == 0) gap_cnt[ch] = g;
        fb[ch].push_back(b);
        fg[ch].push_back(g);
    endtask

    task automatic push_word(input int ch, input logic [7:0] hi, input logic [7:0] lo);
        exp_t e;
        push_byte(ch, hi, 0);
        push_byte(ch, lo, 0);
        e.ch = 2'(ch);
        e.d  = {hi, lo};
        sb_w.push_back(e);
    endtask

    task automatic clear_feeds();
        for (int i = 0; i < NC; i++) begin
            fb[i].delete();
            fg[i].delete();
            gap_cnt[i] = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (valid_out) begin
            check_eq("word_expected", 32'(sb_w.size() > 0), 32'd1);
            if (sb_w.size() > 0) begin
                e = sb_w.pop_front();
                check_eq("data_out", 32'(data_out), 32'(e.d));
                check_eq("ch_out", 32'(ch_out), 32'(e.ch));
                check_eq("word_latency", 32'(cyc), 32'(hs_cyc[e.ch]));
            end
            vq.push_back(cyc);
        end
        if (err_timeout) begin
            check_eq("err_expected", 32'(sb_e.size() > 0), 32'd1);
            if (sb_e.size() > 0) begin
                int ech;
                ech = sb_e.pop_front();
                check_eq("err_ch", 32'(err_ch), 32'(ech));
                check_eq("err_latency", 32'(cyc), 32'(hs_cyc[ech] + TO + 1));
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        logic [3:0] hs;
        hs = req_valid & req_ready;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NC; i++) begin
            if (hs[i]) begin
                void'(fb[i].pop_front());
                void'(fg[i].pop_front());
                hs_cyc[i]  = cyc;
                gap_cnt[i] = (fg[i].size() != 0) ? fg[i][0] : 0;
            end else if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
            end
        end
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain_check(input string tag);
        check_eq({tag, "_words_left"}, 32'(sb_w.size()), 32'd0);
        check_eq({tag, "_errs_left"}, 32'(sb_e.size()), 32'd0);
        sb_w.delete();
        sb_e.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_feeds();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        exp_t e;
        n_chk     = 0;
        n_err     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NC; i++) begin
            gap_cnt[i] = 0;
            hs_cyc[i]  = 0;
        end

        // Reset with random requests: everything stays quiet.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            req_data  = $urandom;
            #2;
            check_eq("rst_valid_out", 32'(valid_out), 32'd0);
            check_eq("rst_data_out", 32'(data_out), 32'd0);
            check_eq("rst_ch_out", 32'(ch_out), 32'd0);
            check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
            check_eq("rst_err_ch", 32'(err_ch), 32'd0);
            check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First grant after reset goes to the lowest requester (ch1 before ch2).
        push_word(1, 8'hA5, 8'h3C);
        push_word(2, 8'hB0, 8'hB1);
        drive();
        run(12);
        drain_check("first_grant");

        // Single channel streaming: 3-cycle word rate.
        base = vq.size();
        push_word(1, 8'hA5, 8'h3C);
        push_word(1, 8'h01, 8'h02);
        push_word(1, 8'hFE, 8'hDC);
        drive();
        run(14);
        drain_check("stream");
        check_eq("word_count_stream", 32'(vq.size() - base), 32'd3);
        if (vq.size() >= base + 3) begin
            check_eq("rate_1", 32'(vq[base+1] - vq[base]), 32'd3);
            check_eq("rate_2", 32'(vq[base+2] - vq[base+1]), 32'd3);
        end

        // Contention: ch0 and ch2 alternate, never interleaving bytes.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_word(0, 8'h11, 8'h22);
            push_word(2, 8'h33, 8'h44);
        end
        // push_word queued ch0/ch2 alternately, which is the expected order.
        drive();
        run(25);
        drain_check("contention");

        // Timeout: ch3 stalls 15 cycles after its first byte; ch0 goes next.
        do_reset();
        push_byte(3, 8'h55, 0);
        drive();
        run(3);
        push_word(0, 8'h01, 8'h02);
        sb_e.push_back(3);
        drive();
        run(30);
        drain_check("timeout");

        // A 14-cycle stall still completes the pair.
        do_reset();
        push_byte(3, 8'h55, 0);
        push_byte(3, 8'h66, TO - 1);
        e.ch = 2'd3;
        e.d  = 16'h5566;
        sb_w.push_back(e);
        drive();
        run(25);
        drain_check("stall_14");

        // Wrap: after ch2 completes ptr=3, so ch3 wins over ch0.
        do_reset();
        push_word(2, 8'hC1, 8'hC2);
        drive();
        run(6);
        push_word(3, 8'hE0, 8'hE1);
        push_word(0, 8'hD0, 8'hD1);
        drive();
        run(12);
        drain_check("wrap");

        // Async reset while holding a partial pair in BYTE1.
        do_reset();
        push_word(1, 8'h12, 8'h34);
        drive();
        run(6);
        push_byte(1, 8'h77, 0);
        drive();
        run(3);
        check_eq("pre_rst_data_out", 32'(data_out), 32'h1234);
        check_eq("pre_rst_ready", 32'(req_ready), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_data_out", 32'(data_out), 32'd0);
        check_eq("async_ch_out", 32'(ch_out), 32'd0);
        check_eq("async_valid_out", 32'(valid_out), 32'd0);
        check_eq("async_req_ready", 32'(req_ready), 32'd0);
        clear_feeds();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(20);
        push_word(2, 8'h9A, 8'hBC);
        drive();
        run(10);
        drain_check("async_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_width_8to16_arb
